// File: rtl/alu_pkg.sv
// Shared definitions for the 6502-style ALU sequencer: ALU mode codes, opcodes,
// addressing kinds, flag bit positions and the sequencer FSM states.
package alu_pkg;

  typedef logic [4:0] alu_mode_t;

  localparam alu_mode_t AluPass = 5'd0;
  localparam alu_mode_t AluOra  = 5'd1;
  localparam alu_mode_t AluAnd  = 5'd2;
  localparam alu_mode_t AluEor  = 5'd3;
  localparam alu_mode_t AluAdc  = 5'd4;
  localparam alu_mode_t AluSbc  = 5'd5;
  localparam alu_mode_t AluAsl  = 5'd6;
  localparam alu_mode_t AluRol  = 5'd7;
  localparam alu_mode_t AluLsr  = 5'd8;
  localparam alu_mode_t AluRor  = 5'd9;

  localparam logic [7:0] OpOraImm = 8'h09;
  localparam logic [7:0] OpOraZp  = 8'h05;
  localparam logic [7:0] OpAndImm = 8'h29;
  localparam logic [7:0] OpAndZp  = 8'h25;
  localparam logic [7:0] OpEorImm = 8'h49;
  localparam logic [7:0] OpEorZp  = 8'h45;
  localparam logic [7:0] OpAdcImm = 8'h69;
  localparam logic [7:0] OpAdcZp  = 8'h65;
  localparam logic [7:0] OpSbcImm = 8'hE9;
  localparam logic [7:0] OpSbcZp  = 8'hE5;
  localparam logic [7:0] OpAslAcc = 8'h0A;
  localparam logic [7:0] OpRolAcc = 8'h2A;
  localparam logic [7:0] OpLsrAcc = 8'h4A;
  localparam logic [7:0] OpRorAcc = 8'h6A;
  localparam logic [7:0] OpClc    = 8'h18;
  localparam logic [7:0] OpSec    = 8'h38;

  // Flag vector layout is {N,V,Z,C}.
  localparam int unsigned FlagN = 3;
  localparam int unsigned FlagV = 2;
  localparam int unsigned FlagZ = 1;
  localparam int unsigned FlagC = 0;

  localparam logic [3:0] MaskNone  = 4'b0000;
  localparam logic [3:0] MaskLogic = 4'b1010;
  localparam logic [3:0] MaskArith = 4'b1111;
  localparam logic [3:0] MaskShift = 4'b1011;
  localparam logic [3:0] MaskCarry = 4'b0001;

  typedef enum logic [1:0] {AddrImm, AddrZp, AddrAcc, AddrFlag} addr_kind_e;

  typedef enum logic [1:0] {StIdle, StRd, StWait, StExec} seq_state_e;

endpackage

// File: rtl/alu_decode.sv
// Combinational opcode decoder: ALU mode, addressing kind, flag-update mask, legality.
module alu_decode
  import alu_pkg::*;
(
  input  logic [7:0] op_code,
  output alu_mode_t  alu_mode,
  output addr_kind_e addr_kind,
  output logic [3:0] flag_mask,
  output logic       legal
);

  // Table lookup; unknown opcodes fall through as illegal with no side effects.
  always_comb begin
    alu_mode  = AluPass;
    addr_kind = AddrAcc;
    flag_mask = MaskNone;
    legal     = 1'b1;
    unique case (op_code)
      OpOraImm: begin alu_mode = AluOra; addr_kind = AddrImm; flag_mask = MaskLogic; end
      OpOraZp:  begin alu_mode = AluOra; addr_kind = AddrZp;  flag_mask = MaskLogic; end
      OpAndImm: begin alu_mode = AluAnd; addr_kind = AddrImm; flag_mask = MaskLogic; end
      OpAndZp:  begin alu_mode = AluAnd; addr_kind = AddrZp;  flag_mask = MaskLogic; end
      OpEorImm: begin alu_mode = AluEor; addr_kind = AddrImm; flag_mask = MaskLogic; end
      OpEorZp:  begin alu_mode = AluEor; addr_kind = AddrZp;  flag_mask = MaskLogic; end
      OpAdcImm: begin alu_mode = AluAdc; addr_kind = AddrImm; flag_mask = MaskArith; end
      OpAdcZp:  begin alu_mode = AluAdc; addr_kind = AddrZp;  flag_mask = MaskArith; end
      OpSbcImm: begin alu_mode = AluSbc; addr_kind = AddrImm; flag_mask = MaskArith; end
      OpSbcZp:  begin alu_mode = AluSbc; addr_kind = AddrZp;  flag_mask = MaskArith; end
      OpAslAcc: begin alu_mode = AluAsl; flag_mask = MaskShift; end
      OpRolAcc: begin alu_mode = AluRol; flag_mask = MaskShift; end
      OpLsrAcc: begin alu_mode = AluLsr; flag_mask = MaskShift; end
      OpRorAcc: begin alu_mode = AluRor; flag_mask = MaskShift; end
      OpClc:    begin addr_kind = AddrFlag; flag_mask = MaskCarry; end
      OpSec:    begin addr_kind = AddrFlag; flag_mask = MaskCarry; end
      default:  legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Sequences one 6502-style opcode at a time through an external combinational ALU,
// fetching zero-page operands when needed and maintaining acc and {N,V,Z,C}.
module alu_sequencer
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic [7:0] op_code,
  input  logic [7:0] op_arg,
  output logic       mem_rd,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rdata,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [4:0] alu_mode,
  output logic       alu_carry_in,
  input  logic [7:0] alu_result,
  input  logic       alu_carry,
  input  logic       alu_overflow,
  output logic [7:0] acc,
  output logic [3:0] flags,
  output logic       done,
  output logic       illegal
);

  seq_state_e state_q;
  alu_mode_t  mode_q;
  addr_kind_e kind_q;
  logic [3:0] mask_q;
  logic       legal_q;
  logic       carry_val_q;
  logic [7:0] operand_q;
  logic [7:0] acc_q;
  logic [3:0] flags_q;
  logic       done_q;
  logic       illegal_q;
  logic       mem_rd_q;
  logic [7:0] mem_addr_q;

  alu_mode_t  dec_mode;
  addr_kind_e dec_kind;
  logic [3:0] dec_mask;
  logic       dec_legal;
  logic [3:0] new_flags;
  logic [3:0] flags_next;

  alu_decode u_decode (
    .op_code   (op_code),
    .alu_mode  (dec_mode),
    .addr_kind (dec_kind),
    .flag_mask (dec_mask),
    .legal     (dec_legal)
  );

  assign op_ready = (state_q == StIdle);
  assign acc      = acc_q;
  assign flags    = flags_q;
  assign done     = done_q;
  assign illegal  = illegal_q;
  assign mem_rd   = mem_rd_q;
  assign mem_addr = mem_addr_q;

  // ALU operands: live operation only in EXEC, a harmless PASS otherwise.
  always_comb begin
    alu_a        = acc_q;
    alu_b        = 8'h00;
    alu_mode     = AluPass;
    alu_carry_in = flags_q[FlagC];
    if (state_q == StExec) begin
      alu_b    = operand_q;
      alu_mode = mode_q;
    end
  end

  // Candidate flags from the ALU, merged into the old flags under the opcode's mask.
  always_comb begin
    new_flags        = {alu_result[7], alu_overflow, (alu_result == 8'h00), alu_carry};
    if (kind_q == AddrFlag) new_flags[FlagC] = carry_val_q;
    flags_next       = (flags_q & ~mask_q) | (new_flags & mask_q);
  end

  // Sequencer FSM with registered strobes; reset aborts any instruction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      mode_q      <= AluPass;
      kind_q      <= AddrAcc;
      mask_q      <= MaskNone;
      legal_q     <= 1'b0;
      carry_val_q <= 1'b0;
      operand_q   <= 8'h00;
      acc_q       <= 8'h00;
      flags_q     <= 4'b0000;
      done_q      <= 1'b0;
      illegal_q   <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= 8'h00;
    end else begin
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      mem_rd_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (op_valid) begin
            mode_q      <= dec_mode;
            kind_q      <= dec_kind;
            mask_q      <= dec_mask;
            legal_q     <= dec_legal;
            // CLC (18) and SEC (38) differ only in bit 5, which is the new carry.
            carry_val_q <= op_code[5];
            if (dec_kind == AddrZp) begin
              mem_rd_q   <= 1'b1;
              mem_addr_q <= op_arg;
              state_q    <= StRd;
            end else begin
              if (dec_kind == AddrImm) operand_q <= op_arg;
              state_q <= StExec;
            end
          end
        end
        StRd: state_q <= StWait;
        StWait: begin
          operand_q <= mem_rdata;
          state_q   <= StExec;
        end
        StExec: begin
          if (legal_q && (kind_q != AddrFlag)) acc_q <= alu_result;
          flags_q   <= flags_next;
          done_q    <= 1'b1;
          illegal_q <= ~legal_q;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
